// File: rtl/pll_pi_filter.sv
// PI loop filter for the ADPLL: PFD up/down pulses in, DCO tuning word out.
// Clamped anti-windup integrator; a window-based lock monitor selects acquire or track gains.
module pll_pi_filter #(
  parameter int unsigned     FTW_W    = 32,
  parameter int unsigned     INT_W    = 40,
  parameter longint unsigned INIT_FTW = 64'd42949673,
  parameter int              KP_ACQ   = 1000,
  parameter int              KI_ACQ   = 10,
  parameter int              KP_TRK   = 250,
  parameter int              KI_TRK   = 2,
  parameter longint unsigned FTW_MIN  = 64'd0,
  parameter longint unsigned FTW_MAX  = (64'd1 << FTW_W) - 64'd1,
  parameter int unsigned     LOCK_WIN = 1024,
  parameter int unsigned     LOCK_TOL = 4,
  parameter int unsigned     LOCK_N   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up,
  input  logic             down,
  input  logic             hold,
  input  logic             clear,
  output logic [FTW_W-1:0] tuning_word,
  output logic             locked,
  output logic             mode,
  output logic             saturated
);

  localparam int unsigned AW     = INT_W + 2;
  localparam int unsigned WIN_W  = (LOCK_WIN > 1) ? $clog2(LOCK_WIN) : 1;
  localparam int unsigned ERR_W  = $clog2(LOCK_WIN + 1);
  localparam int unsigned GOOD_W = $clog2(LOCK_N + 1);

  typedef logic signed [AW-1:0] acc_t;

  localparam acc_t INIT_S = acc_t'(INIT_FTW);
  localparam acc_t MIN_S  = acc_t'(FTW_MIN);
  localparam acc_t MAX_S  = acc_t'(FTW_MAX);
  localparam acc_t IMIN_S = MIN_S - INIT_S;
  localparam acc_t IMAX_S = MAX_S - INIT_S;
  localparam acc_t KPA_S  = acc_t'(KP_ACQ);
  localparam acc_t KIA_S  = acc_t'(KI_ACQ);
  localparam acc_t KPT_S  = acc_t'(KP_TRK);
  localparam acc_t KIT_S  = acc_t'(KI_TRK);

  typedef enum logic {ST_ACQ, ST_TRK} state_t;

  state_t                    state;
  logic signed [INT_W-1:0]   integ;
  logic        [WIN_W-1:0]   win_cnt;
  logic        [ERR_W-1:0]   err_cnt;
  logic        [GOOD_W-1:0]  good_cnt;

  logic                      err_p;
  logic                      err_n;
  acc_t                      kp;
  acc_t                      ki;
  acc_t                      integ_sum;
  acc_t                      integ_nxt;
  acc_t                      raw;
  acc_t                      ftw_nxt;
  logic                      sat_nxt;
  logic                      win_end;
  logic                      win_good;
  logic        [ERR_W-1:0]   err_tot;
  logic        [GOOD_W-1:0]  good_inc;

  // Datapath: integrator is clamped before the proportional term is added,
  // so the stored state never winds past what the output range can use.
  always_comb begin
    err_p     = up & ~down;
    err_n     = down & ~up;
    kp        = mode ? KPT_S : KPA_S;
    ki        = mode ? KIT_S : KIA_S;
    integ_sum = acc_t'(integ);
    if (err_p)
      integ_sum = integ_sum + ki;
    else if (err_n)
      integ_sum = integ_sum - ki;
    if (integ_sum < IMIN_S)
      integ_nxt = IMIN_S;
    else if (integ_sum > IMAX_S)
      integ_nxt = IMAX_S;
    else
      integ_nxt = integ_sum;
    raw = INIT_S + integ_nxt;
    if (err_p)
      raw = raw + kp;
    else if (err_n)
      raw = raw - kp;
    if (raw < MIN_S)
      ftw_nxt = MIN_S;
    else if (raw > MAX_S)
      ftw_nxt = MAX_S;
    else
      ftw_nxt = raw;
    sat_nxt = (raw != ftw_nxt);
  end

  // Lock monitor decode; the window-end verdict includes the current cycle's error.
  always_comb begin
    win_end  = (win_cnt == WIN_W'(LOCK_WIN - 1));
    err_tot  = err_cnt + ERR_W'(err_p | err_n);
    win_good = (32'(err_tot) <= LOCK_TOL);
    good_inc = (good_cnt == GOOD_W'(LOCK_N)) ? good_cnt : good_cnt + GOOD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ACQ;
      integ       <= '0;
      tuning_word <= FTW_W'(INIT_FTW);
      saturated   <= 1'b0;
      locked      <= 1'b0;
      mode        <= 1'b0;
      win_cnt     <= '0;
      err_cnt     <= '0;
      good_cnt    <= '0;
    end else if (clear) begin
      state       <= ST_ACQ;
      integ       <= '0;
      tuning_word <= FTW_W'(INIT_FTW);
      saturated   <= 1'b0;
      locked      <= 1'b0;
      mode        <= 1'b0;
      win_cnt     <= '0;
      err_cnt     <= '0;
      good_cnt    <= '0;
    end else if (!hold) begin
      integ       <= integ_nxt[INT_W-1:0];
      tuning_word <= ftw_nxt[FTW_W-1:0];
      saturated   <= sat_nxt;
      if (win_end) begin
        win_cnt <= '0;
        err_cnt <= '0;
        if (win_good) begin
          good_cnt <= good_inc;
          if (state == ST_ACQ && good_inc == GOOD_W'(LOCK_N)) begin
            state  <= ST_TRK;
            locked <= 1'b1;
            mode   <= 1'b1;
          end
        end else begin
          good_cnt <= '0;
          state    <= ST_ACQ;
          locked   <= 1'b0;
          mode     <= 1'b0;
        end
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        err_cnt <= err_tot;
      end
    end
  end

endmodule
